// File: rtl/inst_mem_axi_slv_pkg.sv
// Shared AXI widths, response/burst codes and record layouts for the
// instruction-memory AXI read slave.
package inst_mem_axi_slv_pkg;

  localparam int AXI_ID_WIDTH    = 4;
  localparam int AXI_ADDR_WIDTH  = 32;
  localparam int AXI_DATA_WIDTH  = 32;
  localparam int AXI_LEN_WIDTH   = 8;
  localparam int AXI_SIZE_WIDTH  = 3;
  localparam int AXI_BURST_WIDTH = 2;
  localparam int AXI_RESP_WIDTH  = 2;

  localparam logic [AXI_RESP_WIDTH-1:0]  AXI_RESP_OKAY   = 2'b00;
  localparam logic [AXI_RESP_WIDTH-1:0]  AXI_RESP_SLVERR = 2'b10;

  localparam logic [AXI_BURST_WIDTH-1:0] AXI_BURST_FIXED = 2'b00;
  localparam logic [AXI_BURST_WIDTH-1:0] AXI_BURTS_INCR  = 2'b01;
  localparam logic [AXI_BURST_WIDTH-1:0] AXI_BURST_WRAP  = 2'b10;

  localparam int                         INST_MEM_DEPTH_W   = 12;
  localparam logic [AXI_ADDR_WIDTH-1:0]  INST_MEM_BASE_ADDR = 32'h8000_0000;

  typedef enum logic {ST_IDLE, ST_BURST} engState_e;

  typedef struct packed {
    logic [AXI_ID_WIDTH-1:0]    id;
    logic [AXI_ADDR_WIDTH-1:0]  addr;
    logic [AXI_LEN_WIDTH-1:0]   len;
    logic [AXI_SIZE_WIDTH-1:0]  size;
    logic [AXI_BURST_WIDTH-1:0] burst;
  } arReq_t;

  typedef struct packed {
    logic [AXI_ID_WIDTH-1:0]   id;
    logic [AXI_DATA_WIDTH-1:0] data;
    logic [AXI_RESP_WIDTH-1:0] resp;
    logic                      last;
  } rBeat_t;

  // Request-level faults: beats wider than a word, WRAP or the reserved burst type.
  function automatic logic reqFieldError(input logic [AXI_SIZE_WIDTH-1:0] size,
                                         input logic [AXI_BURST_WIDTH-1:0] burst);
    return (size > 3'd2) || (burst == AXI_BURST_WRAP) || (burst == 2'b11);
  endfunction

endpackage

// File: rtl/inst_mem_axi_slv_fifo.sv
// Small synchronous FIFO with registered occupancy; full/empty derive from
// the count register only, so a same-cycle pop never frees a slot early.
module inst_mem_axi_slv_fifo #(
  parameter int WIDTH   = 8,
  parameter int DEPTH   = 2,
  parameter int DEPTH_W = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               push_i,
  input  logic [WIDTH-1:0]   data_i,
  input  logic               pop_i,
  output logic [WIDTH-1:0]   data_o,
  output logic               full_o,
  output logic               empty_o,
  output logic [DEPTH_W:0]   count_o
);

  logic [WIDTH-1:0]   mem_q [DEPTH];
  logic [DEPTH_W-1:0] wrPtr_q;
  logic [DEPTH_W-1:0] rdPtr_q;
  logic [DEPTH_W:0]   count_q;
  logic               doPush;
  logic               doPop;

  assign full_o  = (count_q == (DEPTH_W+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign doPush  = push_i && !full_o;
  assign doPop   = pop_i && !empty_o;
  assign data_o  = mem_q[rdPtr_q];
  assign count_o = count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (doPush) begin
        mem_q[wrPtr_q] <= data_i;
        wrPtr_q        <= wrPtr_q + DEPTH_W'(1);
      end
      if (doPop) rdPtr_q <= rdPtr_q + DEPTH_W'(1);
      case ({doPush, doPop})
        2'b10:   count_q <= count_q + (DEPTH_W+1)'(1);
        2'b01:   count_q <= count_q - (DEPTH_W+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/inst_mem_axi_slv.sv
// AXI4 read-only instruction memory: queued AR requests, FIXED/INCR burst
// engine over a synchronous word RAM, in-order R responses with backpressure.
module inst_mem_axi_slv
  import inst_mem_axi_slv_pkg::*;
#(
  parameter int                        MEM_DEPTH_W    = INST_MEM_DEPTH_W,
  parameter int                        AR_FIFO_DEEP   = 4,
  parameter int                        AR_FIFO_DEEP_W = 2,
  parameter logic [AXI_ADDR_WIDTH-1:0] BASE_ADDR      = INST_MEM_BASE_ADDR
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       s_arvalid,
  output logic                       s_arready,
  input  logic [AXI_ID_WIDTH-1:0]    s_arid,
  input  logic [AXI_ADDR_WIDTH-1:0]  s_araddr,
  input  logic [AXI_LEN_WIDTH-1:0]   s_arlen,
  input  logic [AXI_SIZE_WIDTH-1:0]  s_arsize,
  input  logic [AXI_BURST_WIDTH-1:0] s_arburst,
  input  logic                       s_arlock,
  input  logic [3:0]                 s_arcache,
  input  logic [2:0]                 s_arprot,
  input  logic [3:0]                 s_arqos,
  input  logic [3:0]                 s_arregion,
  output logic                       s_rvalid,
  input  logic                       s_rready,
  output logic [AXI_ID_WIDTH-1:0]    s_rid,
  output logic [AXI_DATA_WIDTH-1:0]  s_rdata,
  output logic [AXI_RESP_WIDTH-1:0]  s_rresp,
  output logic                       s_rlast,
  input  logic                       ld_wr_en,
  input  logic [MEM_DEPTH_W-1:0]     ld_wr_addr,
  input  logic [AXI_DATA_WIDTH-1:0]  ld_wr_data
);

  localparam int MEM_WORDS = 1 << MEM_DEPTH_W;

  arReq_t                      arPush, arHead;
  logic                        arFull, arEmpty, arPop;
  logic [AR_FIFO_DEEP_W:0]     arCount;
  rBeat_t                      rPush, rHead;
  logic                        rFull, rEmpty, rPop;
  logic [1:0]                  rCount;
  logic [2:0]                  rLoad;
  logic                        canIssue, headReady, issue, beatErr;

  engState_e                   state_q;
  logic [AXI_LEN_WIDTH-1:0]    cnt_q;
  logic [AXI_ADDR_WIDTH-1:0]   curAddr_q;
  logic [AXI_ID_WIDTH-1:0]     id_q;
  logic [AXI_SIZE_WIDTH-1:0]   size_q;
  logic [AXI_BURST_WIDTH-1:0]  burst_q;

  logic [AXI_ID_WIDTH-1:0]     selId;
  logic [AXI_ADDR_WIDTH-1:0]   selAddr, offset, nextAddr;
  logic [AXI_LEN_WIDTH-1:0]    selLen;
  logic [AXI_SIZE_WIDTH-1:0]   selSize;
  logic [AXI_BURST_WIDTH-1:0]  selBurst;

  logic                        inflight_q, infLast_q, infErr_q;
  logic [AXI_ID_WIDTH-1:0]     infId_q;
  logic [AXI_DATA_WIDTH-1:0]   memRdData_q;
  logic [AXI_DATA_WIDTH-1:0]   mem [MEM_WORDS];
  logic                        unusedSink;

  assign s_arready = !arFull;
  assign arPush    = '{id: s_arid, addr: s_araddr, len: s_arlen, size: s_arsize, burst: s_arburst};

  inst_mem_axi_slv_fifo #(
    .WIDTH($bits(arReq_t)), .DEPTH(AR_FIFO_DEEP), .DEPTH_W(AR_FIFO_DEEP_W)
  ) u_arFifo (
    .clk(clk), .rst_n(rst_n), .push_i(s_arvalid && s_arready), .data_i(arPush),
    .pop_i(arPop), .data_o(arHead), .full_o(arFull), .empty_o(arEmpty), .count_o(arCount)
  );

  // In IDLE the head request drives the first beat directly, so pop and issue coincide.
  always_comb begin
    selId    = id_q;
    selAddr  = curAddr_q;
    selLen   = cnt_q;
    selSize  = size_q;
    selBurst = burst_q;
    if (state_q == ST_IDLE) begin
      selId    = arHead.id;
      selAddr  = arHead.addr;
      selLen   = arHead.len;
      selSize  = arHead.size;
      selBurst = arHead.burst;
    end
  end

  assign offset   = selAddr - BASE_ADDR;
  assign beatErr  = reqFieldError(selSize, selBurst) || (|offset[AXI_ADDR_WIDTH-1:MEM_DEPTH_W+2]);
  assign nextAddr = (selBurst == AXI_BURTS_INCR) ? selAddr + (AXI_ADDR_WIDTH'(1) << selSize) : selAddr;

  // Credit counts the beat leaving this cycle so a full-rate stream keeps flowing.
  assign rPop      = s_rvalid && s_rready;
  assign rLoad     = 3'(rCount) + 3'(inflight_q) - 3'(rPop);
  assign canIssue  = (rLoad < 3'd2);
  assign headReady = (state_q == ST_IDLE) && !arEmpty;
  assign issue     = canIssue && (headReady || (state_q == ST_BURST));
  assign arPop     = headReady && canIssue;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      curAddr_q <= '0;
      id_q      <= '0;
      size_q    <= '0;
      burst_q   <= '0;
    end else if (issue) begin
      curAddr_q <= nextAddr;
      cnt_q     <= selLen - AXI_LEN_WIDTH'(1);
      id_q      <= selId;
      size_q    <= selSize;
      burst_q   <= selBurst;
      state_q   <= (selLen == '0) ? ST_IDLE : ST_BURST;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight_q <= 1'b0;
      infId_q    <= '0;
      infLast_q  <= 1'b0;
      infErr_q   <= 1'b0;
    end else begin
      inflight_q <= issue;
      if (issue) begin
        infId_q   <= selId;
        infLast_q <= (selLen == '0);
        infErr_q  <= beatErr;
      end
    end
  end

  // Read and loader write share one edge; the read sees the pre-write word.
  always_ff @(posedge clk) begin
    if (ld_wr_en) mem[ld_wr_addr] <= ld_wr_data;
    if (issue) memRdData_q <= mem[offset[MEM_DEPTH_W+1:2]];
  end

  assign rPush = '{id:   infId_q,
                   data: infErr_q ? '0 : memRdData_q,
                   resp: infErr_q ? AXI_RESP_SLVERR : AXI_RESP_OKAY,
                   last: infLast_q};

  inst_mem_axi_slv_fifo #(
    .WIDTH($bits(rBeat_t)), .DEPTH(2), .DEPTH_W(1)
  ) u_rFifo (
    .clk(clk), .rst_n(rst_n), .push_i(inflight_q), .data_i(rPush),
    .pop_i(rPop), .data_o(rHead), .full_o(rFull), .empty_o(rEmpty), .count_o(rCount)
  );

  assign s_rvalid = !rEmpty;
  assign s_rid    = rHead.id;
  assign s_rdata  = rHead.data;
  assign s_rresp  = rHead.resp;
  assign s_rlast  = rHead.last;

  assign unusedSink = ^{s_arlock, s_arcache, s_arprot, s_arqos, s_arregion,
                        offset[1:0], rFull, arCount};

endmodule
